// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] PTR_RESET = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate so (ptr+1) lands at bit 0,
// fixed-priority encode, then rotate the index back.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);
  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  assign start = ptr + 3'd1;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      localparam logic [SEL_W-1:0] OFS = SEL_W'(gi);
      logic [SEL_W-1:0] idx;
      assign idx     = OFS + start;
      assign rot[gi] = req[idx];
    end
  endgenerate

  // Scan high to low so the lowest rotated index (closest to ptr+1) wins.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign win = off + start;
  assign any = |req;
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 8:1 mux: registered one-hot grant and select,
// hold timeout, and one dead cycle between consecutive owners.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             timeout
);
  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;
  logic             timeout_q, timeout_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [SEL_W-1:0] win;
  logic             any;
  logic             expire;
  logic             withdrew;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  assign expire   = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign withdrew = ~req[sel_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE, GAP: begin
        if (any) begin
          state_d      = BUSY;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          sel_d        = win;
          sel_valid_d  = 1'b1;
          ptr_d        = win;
          hold_cnt_d   = '0;
        end else begin
          state_d     = IDLE;
          grant_d     = '0;
          sel_valid_d = 1'b0;
        end
      end
      BUSY: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (done || withdrew || expire) begin
          state_d     = GAP;
          grant_d     = '0;
          sel_valid_d = 1'b0;
          // Timeout is flagged only when expiry is the sole reason to release.
          timeout_d   = expire && !done && !withdrew;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        sel_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= PTR_RESET;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;
  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       sel_valid;
  logic       timeout;

  int checks;
  int failures;

  mux_rr_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .sel       (sel),
    .sel_valid (sel_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h at %0t", tag, obs, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_busy(input string tag, input logic [2:0] owner);
    check_eq({tag, "_grant"}, {24'd0, grant}, 32'd1 << owner);
    check_eq({tag, "_sel"}, {29'd0, sel}, {29'd0, owner});
    check_eq({tag, "_valid"}, {31'd0, sel_valid}, 32'd1);
  endtask

  task automatic expect_free(input string tag, input logic exp_to);
    check_eq({tag, "_grant"}, {24'd0, grant}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, sel_valid}, 32'd0);
    check_eq({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    done     = 1'b0;
    tick();
    check_eq("rst_grant", {24'd0, grant}, 32'd0);
    check_eq("rst_sel", {29'd0, sel}, 32'd0);
    check_eq("rst_valid", {31'd0, sel_valid}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request, one-cycle latency, done release into GAP.
    req = 8'h01;
    tick();
    expect_busy("t1_grant", 3'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    expect_free("t1_gap", 1'b0);
    check_eq("t1_gap_sel", {29'd0, sel}, 32'd0);
    tick();
    expect_free("t1_idle", 1'b0);

    // All requesting, done one cycle after each grant: 0..7 then 0.
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      expect_busy($sformatf("t2_own%0d", k), 3'(k % 8));
      done = 1'b1;
      tick();
      done = 1'b0;
      expect_free($sformatf("t2_gap%0d", k), 1'b0);
      tick();
    end
    req = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    expect_free("t2_end", 1'b0);

    // Hold timeout: 16 busy cycles, timeout pulse in GAP, then regrant to 3.
    do_reset();
    req = 8'h08;
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq($sformatf("t3_valid%0d", k), {31'd0, sel_valid}, 32'd1);
      check_eq($sformatf("t3_to%0d", k), {31'd0, timeout}, 32'd0);
    end
    tick();
    expect_free("t3_expire", 1'b1);
    tick();
    expect_busy("t3_regrant", 3'd3);
    check_eq("t3_to_clear", {31'd0, timeout}, 32'd0);
    req = 8'h00;
    tick();
    expect_free("t3_withdraw", 1'b0);
    tick();

    // Owner 5 withdraws; req=0x21 then picks 0 (search from 6).
    do_reset();
    req = 8'h20;
    tick();
    expect_busy("t4_own5", 3'd5);
    req = 8'h01;
    tick();
    expect_free("t4_release", 1'b0);
    check_eq("t4_sel_hold", {29'd0, sel}, 32'd5);
    req = 8'h21;
    tick();
    expect_busy("t4_next", 3'd0);

    // Owner 5 again (ptr=0), then async reset mid-cycle.
    done = 1'b1;
    req  = 8'h20;
    tick();
    done = 1'b0;
    tick();
    expect_busy("t5_own5", 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_grant", {24'd0, grant}, 32'd0);
    check_eq("t5_async_valid", {31'd0, sel_valid}, 32'd0);
    req = 8'h81;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_busy("t5_after_rst", 3'd0);

    // Owner 2 ignores other request bits; then winner from ptr=2 is 6.
    done = 1'b1;
    req  = 8'h04;
    tick();
    done = 1'b0;
    tick();
    expect_busy("t6_own2", 3'd2);
    req = 8'h46;
    tick();
    expect_busy("t6_tog_a", 3'd2);
    req = 8'h06;
    tick();
    expect_busy("t6_tog_b", 3'd2);
    req = 8'h46;
    tick();
    expect_busy("t6_tog_c", 3'd2);
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_free("t6_gap", 1'b0);
    tick();
    expect_busy("t6_next", 3'd6);

    // done outside BUSY is ignored: GAP then idle with no request.
    req  = 8'h00;
    tick();
    done = 1'b1;
    tick();
    expect_free("t7_idle_done", 1'b0);
    done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
